// File: rtl/mem_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
// Optional build macro MEM_MISALIGN_TRAP_EN is consumed by lsu_align and mem_stage_lsu.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } lsu_state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic            reg_write;
    logic            result_src;
    logic            wd3_src;
  } wb_reg_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte-enables/replication and load extract/extend.
// With MEM_MISALIGN_TRAP_EN defined it also reports misaligned halfword/word accesses.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]      size,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sign_ext;

  // Halfword lane is chosen by off[1] only, so odd halfword addresses force-align.
  always_comb begin
    ld_byte   = load_word[{off, 3'b000} +: 8];
    ld_half   = off[1] ? load_word[31:16] : load_word[15:0];
    sign_ext  = (size == LB) || (size == LH);
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign  = 1'b0;
`endif
    case (size)
      LB, LBU: begin
        be        = 4'b0001 << off;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      end
      LH, LHU: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{sign_ext & ld_half[15]}}, ld_half};
`ifdef MEM_MISALIGN_TRAP_EN
        misalign  = off[0];
`endif
      end
      default: begin
`ifdef MEM_MISALIGN_TRAP_EN
        misalign  = |off;
`endif
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the valid/ready data bus, stalls upstream while an
// access is outstanding, and holds the MEM-to-WB register. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [WIDTH-1:0] PCPlus4M,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             ResultSrcM,
  input  logic             WDMEM,
  input  logic             WD3SrcM,
  input  logic [2:0]       MemSizeM,
  output logic             StallMem,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_req_we,
  output logic [WIDTH-1:0] dmem_req_addr,
  output logic [WIDTH-1:0] dmem_req_wdata,
  output logic [3:0]       dmem_req_be,
  input  logic             dmem_rsp_valid,
  input  logic [WIDTH-1:0] dmem_rsp_rdata,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic             WD3SrcW
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             MisalignW
`endif
);

  lsu_state_t  state_q, state_d;
  wb_reg_t     w_q, w_d;
  logic        is_load, is_store, mem_op, mem_access, done;
  logic [WIDTH-1:0] load_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign, trap, misalign_q, misalign_d;
`endif

  lsu_align u_align (
    .size       (MemSizeM),
    .off        (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .load_word  (dmem_rsp_rdata),
    .be         (dmem_req_be),
    .wdata      (dmem_req_wdata),
    .load_data  (load_data)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  // A simultaneous load+store request is treated as a load.
  assign is_load  = ResultSrcM;
  assign is_store = WDMEM & ~ResultSrcM;
  assign mem_op   = is_load | WDMEM;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap       = mem_op & misalign;
  assign mem_access = mem_op & ~trap;
`else
  assign mem_access = mem_op;
`endif

  assign dmem_req_addr = {ALUResultM[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_access) begin
          if (!dmem_req_ready)  state_d = REQ;
          else if (is_load)     state_d = WAIT_RSP;
        end
      end
      REQ: begin
        if (dmem_req_ready) state_d = is_load ? WAIT_RSP : IDLE;
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE doubles as the first request cycle, so the bus sees valid without a dead cycle.
  always_comb begin
    dmem_req_valid = 1'b0;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req_valid = mem_access;
        done           = ~mem_access | (is_store & dmem_req_ready);
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        done           = is_store & dmem_req_ready;
      end
      WAIT_RSP: done = dmem_rsp_valid;
      default:  done = 1'b0;
    endcase
    if (rst) dmem_req_valid = 1'b0;
    dmem_req_we = dmem_req_valid & is_store;
    StallMem    = ~rst & ~done;
  end

  // Anything short of completion writes a bubble into the WB register.
  always_comb begin
    w_d = '0;
    if (done) begin
      w_d.alu_result = ALUResultM;
      w_d.pc_plus4   = PCPlus4M;
      w_d.rd         = RdM;
      w_d.reg_write  = RegWriteM;
      w_d.result_src = ResultSrcM;
      w_d.wd3_src    = WD3SrcM;
      if (state_q == WAIT_RSP) w_d.read_data = load_data;
`ifdef MEM_MISALIGN_TRAP_EN
      if (trap) w_d.reg_write = 1'b0;
`endif
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign_d = done & trap;
  end

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign MisalignW = misalign_q;
`endif

  assign ALUResultW = w_q.alu_result;
  assign ReadDataW  = w_q.read_data;
  assign PCPlus4W   = w_q.pc_plus4;
  assign RdW        = w_q.rd;
  assign RegWriteW  = w_q.reg_write;
  assign ResultSrcW = w_q.result_src;
  assign WD3SrcW    = w_q.wd3_src;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed scoreboard bench for mem_stage_lsu; expected WB records are queued when an op
// is driven and popped on the edge that completes it. Trap cases need MEM_MISALIGN_TRAP_EN.
module tb_mem_stage_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, ResultSrcM, WDMEM, WD3SrcM;
  logic [2:0]  MemSizeM;
  logic        StallMem;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW, ResultSrcW, WD3SrcW;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic        rs;
    logic        wd3;
    logic        chk_rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ALUResultM     (ALUResultM),
    .WriteDataM     (WriteDataM),
    .PCPlus4M       (PCPlus4M),
    .RdM            (RdM),
    .RegWriteM      (RegWriteM),
    .ResultSrcM     (ResultSrcM),
    .WDMEM          (WDMEM),
    .WD3SrcM        (WD3SrcM),
    .MemSizeM       (MemSizeM),
    .StallMem       (StallMem),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_be    (dmem_req_be),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .ALUResultW     (ALUResultW),
    .ReadDataW      (ReadDataW),
    .PCPlus4W       (PCPlus4W),
    .RdW            (RdW),
    .RegWriteW      (RegWriteW),
    .ResultSrcW     (ResultSrcW),
    .WD3SrcW        (WD3SrcW)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .MisalignW      (MisalignW)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                               input logic [4:0] rd, input logic rw, input logic rs,
                               input logic wdm, input logic wd3, input logic [2:0] size);
    ALUResultM = alu;
    WriteDataM = wd;
    PCPlus4M   = pc;
    RdM        = rd;
    RegWriteM  = rw;
    ResultSrcM = rs;
    WDMEM      = wdm;
    WD3SrcM    = wd3;
    MemSizeM   = size;
  endtask

  task automatic applyNoop();
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LW);
  endtask

  task automatic pushExp(input string tag, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic rs, input logic wd3, input logic chk);
    exp_t e;
    e.tag = tag; e.alu = alu; e.rdata = rdata; e.pc = pc; e.rd = rd;
    e.rw = rw; e.rs = rs; e.wd3 = wd3; e.chk_rdata = chk;
    exp_q.push_back(e);
  endtask

  task automatic popCheck();
    exp_t e;
    checkOutput("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_alu"}, ALUResultW, e.alu);
      checkOutput({e.tag, "_pc"},  PCPlus4W, e.pc);
      checkOutput({e.tag, "_rd"},  {27'd0, RdW}, {27'd0, e.rd});
      checkOutput({e.tag, "_rw"},  {31'd0, RegWriteW}, {31'd0, e.rw});
      checkOutput({e.tag, "_rs"},  {31'd0, ResultSrcW}, {31'd0, e.rs});
      checkOutput({e.tag, "_wd3"}, {31'd0, WD3SrcW}, {31'd0, e.wd3});
      if (e.chk_rdata) checkOutput({e.tag, "_rdata"}, ReadDataW, e.rdata);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Load accepted immediately, response arrives 'delay' cycles after acceptance.
  // Ends just after the completion edge; the caller must drive the next op at once.
  task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int delay);
    logic [31:0] pc;
    pc = 32'h400 + {25'd0, rd, 2'b00};
    nextCycle();
    applyStimulus(addr, 32'h0, pc, rd, 1'b1, 1'b1, 1'b0, 1'b0, size);
    dmem_req_ready = 1'b1;
    dmem_rsp_valid = 1'b0;
    pushExp(tag, addr, exp_data, pc, rd, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'd0, dmem_req_valid}, 32'd1);
    checkOutput({tag, "_addr"},  dmem_req_addr, {addr[31:2], 2'b00});
    checkOutput({tag, "_we"},    {31'd0, dmem_req_we}, 32'd0);
    checkOutput({tag, "_stall0"}, {31'd0, StallMem}, 32'd1);
    for (int d = 1; d <= delay; d++) begin
      nextCycle();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = (d == delay);
      dmem_rsp_rdata = (d == delay) ? rdata : 32'h0;
      @(negedge clk);
      checkOutput({tag, "_stall"}, {31'd0, StallMem}, {31'd0, d != delay});
      checkOutput({tag, "_wvalid"}, {31'd0, dmem_req_valid}, 32'd0);
      if (d == 1) checkOutput({tag, "_bubble"}, {31'd0, RegWriteW}, 32'd0);
    end
    nextCycle();
    dmem_rsp_valid = 1'b0;
    popCheck();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyNoop();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'h0;
    @(posedge clk);
    #1;
    applyStimulus(32'h1000, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, LW);
    @(negedge clk);
    checkOutput("rst_stall", {31'd0, StallMem}, 32'd0);
    checkOutput("rst_valid", {31'd0, dmem_req_valid}, 32'd0);
    checkOutput("rst_alu", ALUResultW, 32'd0);
    checkOutput("rst_rw", {31'd0, RegWriteW}, 32'd0);
    checkOutput("rst_rd", {27'd0, RdW}, 32'd0);
    checkOutput("rst_rdata", ReadDataW, 32'd0);
    nextCycle();
    rst = 1'b0;
    applyNoop();

    // Pass-through ALU op
    nextCycle();
    applyStimulus(32'h1234, 32'h0, 32'h44, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, LW);
    pushExp("pass", 32'h1234, 32'h0, 32'h44, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("pass_stall", {31'd0, StallMem}, 32'd0);
    checkOutput("pass_valid", {31'd0, dmem_req_valid}, 32'd0);
    nextCycle();
    popCheck();
    applyNoop();

    doLoad("lb", 32'h1003, LB, 32'h80FF7F01, 5'd7, 32'hFFFFFF80, 2);
    applyNoop();
    doLoad("lbu", 32'h1003, LBU, 32'h80FF7F01, 5'd8, 32'h00000080, 2);
    applyNoop();

    // Store SH with ready held low for three cycles
    nextCycle();
    applyStimulus(32'h2002, 32'hAAAABEEF, 32'h60, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, LH);
    pushExp("sh", 32'h2002, 32'h0, 32'h60, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nextCycle();
      dmem_req_ready = (i == 3);
      @(negedge clk);
      checkOutput("sh_valid", {31'd0, dmem_req_valid}, 32'd1);
      checkOutput("sh_addr", dmem_req_addr, 32'h2000);
      checkOutput("sh_be", {28'd0, dmem_req_be}, 32'hC);
      checkOutput("sh_wdata", dmem_req_wdata, 32'hBEEFBEEF);
      checkOutput("sh_we", {31'd0, dmem_req_we}, 32'd1);
      checkOutput("sh_stall", {31'd0, StallMem}, {31'd0, i != 3});
    end
    nextCycle();
    dmem_req_ready = 1'b0;
    popCheck();
    applyNoop();

    // Store SB accepted immediately completes without a stall
    nextCycle();
    applyStimulus(32'h5001, 32'h000000A5, 32'h70, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, LB);
    dmem_req_ready = 1'b1;
    pushExp("sb", 32'h5001, 32'h0, 32'h70, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sb_be", {28'd0, dmem_req_be}, 32'h2);
    checkOutput("sb_wdata", dmem_req_wdata, 32'hA5A5A5A5);
    checkOutput("sb_stall", {31'd0, StallMem}, 32'd0);
    nextCycle();
    dmem_req_ready = 1'b0;
    popCheck();
    applyNoop();

    // LW followed immediately by an ALU op
    doLoad("lw", 32'h3000, LW, 32'hDEADBEEF, 5'd10, 32'hDEADBEEF, 1);
    applyStimulus(32'h55, 32'h0, 32'h88, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LW);
    pushExp("alu2", 32'h55, 32'h0, 32'h88, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("alu2_stall", {31'd0, StallMem}, 32'd0);
    nextCycle();
    popCheck();
    checkOutput("b2b_drained", exp_q.size(), 32'd0);
    applyNoop();

    // Reset while waiting for a load response
    nextCycle();
    applyStimulus(32'h4000, 32'h0, 32'h90, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, LW);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    checkOutput("rw_valid", {31'd0, dmem_req_valid}, 32'd1);
    nextCycle();
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rw_rst_stall", {31'd0, StallMem}, 32'd0);
    nextCycle();
    rst = 1'b0;
    applyNoop();
    @(negedge clk);
    checkOutput("rw_w_rw", {31'd0, RegWriteW}, 32'd0);
    checkOutput("rw_w_rd", {27'd0, RdW}, 32'd0);
    checkOutput("rw_w_alu", ALUResultW, 32'd0);
    checkOutput("rw_w_pc", PCPlus4W, 32'd0);
    checkOutput("rw_w_rdata", ReadDataW, 32'd0);
    checkOutput("rw_idle_stall", {31'd0, StallMem}, 32'd0);
    nextCycle();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h12345678;
    @(negedge clk);
    checkOutput("rw_late_stall", {31'd0, StallMem}, 32'd0);
    checkOutput("rw_late_valid", {31'd0, dmem_req_valid}, 32'd0);
    doLoad("lh_after", 32'h4002, LH, 32'h80011234, 5'd12, 32'hFFFF8001, 1);
    applyNoop();

`ifdef MEM_MISALIGN_TRAP_EN
    nextCycle();
    applyStimulus(32'h3001, 32'h0, 32'hA0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, LW);
    dmem_req_ready = 1'b1;
    pushExp("trap", 32'h3001, 32'h0, 32'hA0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("trap_valid", {31'd0, dmem_req_valid}, 32'd0);
    checkOutput("trap_stall", {31'd0, StallMem}, 32'd0);
    nextCycle();
    dmem_req_ready = 1'b0;
    popCheck();
    checkOutput("trap_flag", {31'd0, MisalignW}, 32'd1);
    applyNoop();
    nextCycle();
    checkOutput("trap_clear", {31'd0, MisalignW}, 32'd0);
`else
    doLoad("lhu_fa", 32'h6003, LHU, 32'hBEEF1234, 5'd14, 32'h0000BEEF, 1);
    applyNoop();
    doLoad("lw_fa", 32'h3001, LW, 32'hCAFEF00D, 5'd15, 32'hCAFEF00D, 1);
    applyNoop();
`endif

    nextCycle();
    checkOutput("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
